// File: rtl/ex_stage_if.sv
// ============================================================================
// Module      : ex_stage_if
// Description : ID/EX operand/control bundle into the execute stage and the
//               registered EX/MEM results coming out of it.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface ex_stage_if;
   logic [31:0] readRegister0In;
   logic [31:0] readRegister1In;
   logic [31:0] immediateExtendedIn;
   logic [31:0] pcMore4In;
   logic [4:0]  addressRegisterRtIn;
   logic [4:0]  addressRegisterRdIn;
   logic        regDstIn;
   logic        jumpIn;
   logic        memReadIn;
   logic        memToRegIn;
   logic        memWriteIn;
   logic        aluSrcIn;
   logic        regWriteIn;
   logic [1:0]  branchIn;
   logic [3:0]  aluOpIn;
   logic        flushIn;

   logic        stallOut;
   logic [31:0] aluResultOut;
   logic [31:0] writeDataOut;
   logic [4:0]  writeRegisterOut;
   logic        branchTakenOut;
   logic [31:0] branchTargetOut;
   logic        memReadOut;
   logic        memWriteOut;
   logic        memToRegOut;
   logic        regWriteOut;
   logic        jumpOut;

   modport master (
      output readRegister0In, readRegister1In, immediateExtendedIn, pcMore4In,
             addressRegisterRtIn, addressRegisterRdIn, regDstIn, jumpIn,
             memReadIn, memToRegIn, memWriteIn, aluSrcIn, regWriteIn,
             branchIn, aluOpIn, flushIn,
      input  stallOut, aluResultOut, writeDataOut, writeRegisterOut,
             branchTakenOut, branchTargetOut, memReadOut, memWriteOut,
             memToRegOut, regWriteOut, jumpOut
   );

   modport slave (
      input  readRegister0In, readRegister1In, immediateExtendedIn, pcMore4In,
             addressRegisterRtIn, addressRegisterRdIn, regDstIn, jumpIn,
             memReadIn, memToRegIn, memWriteIn, aluSrcIn, regWriteIn,
             branchIn, aluOpIn, flushIn,
      output stallOut, aluResultOut, writeDataOut, writeRegisterOut,
             branchTakenOut, branchTargetOut, memReadOut, memWriteOut,
             memToRegOut, regWriteOut, jumpOut
   );
endinterface

`default_nettype wire

// File: rtl/ex_stage.sv
// ============================================================================
// Module      : ex_stage
// Description : Execute stage: ALU, BEQ/BNE resolution, 32-step shift-add
//               multiplier with upstream stall, registered EX/MEM outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ex_stage #(
   parameter int MUL_CYCLES = 32
) (
   input  wire logic  clk,
   input  wire logic  reset,
   ex_stage_if.slave  bus
);

   localparam logic [3:0] c_OP_MUL = 4'd12;
   localparam logic [4:0] c_LAST   = 5'(MUL_CYCLES - 1);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_t;

   state_t      r_state, w_state_nxt;
   logic [4:0]  r_count;
   logic [31:0] r_mcand, r_mplier, r_acc;

   logic [31:0] r_alu_result, r_write_data, r_branch_target;
   logic [4:0]  r_write_reg;
   logic        r_branch_taken, r_mem_read, r_mem_write, r_mem_to_reg;
   logic        r_reg_write, r_jump;

   logic [31:0] w_opb, w_alu, w_mul_add, w_acc_nxt;
   logic [4:0]  w_shamt;
   logic        w_stall, w_bubble, w_load, w_step, w_retire_mul, w_taken;

   assign w_opb   = bus.aluSrcIn ? bus.immediateExtendedIn : bus.readRegister1In;
   assign w_shamt = bus.immediateExtendedIn[10:6];

   always_comb begin
      w_alu = 32'd0;
      case (bus.aluOpIn)
         4'd0:    w_alu = bus.readRegister0In + w_opb;
         4'd1:    w_alu = bus.readRegister0In - w_opb;
         4'd2:    w_alu = bus.readRegister0In & w_opb;
         4'd3:    w_alu = bus.readRegister0In | w_opb;
         4'd4:    w_alu = bus.readRegister0In ^ w_opb;
         4'd5:    w_alu = ~(bus.readRegister0In | w_opb);
         4'd6:    w_alu = {31'd0, $signed(bus.readRegister0In) < $signed(w_opb)};
         4'd7:    w_alu = {31'd0, bus.readRegister0In < w_opb};
         4'd8:    w_alu = w_opb << w_shamt;
         4'd9:    w_alu = w_opb >> w_shamt;
         4'd10:   w_alu = $signed(w_opb) >>> w_shamt;
         4'd11:   w_alu = {bus.immediateExtendedIn[15:0], 16'd0};
         default: w_alu = 32'd0;
      endcase
   end

   // Branch compare always uses the rt register value, never the immediate.
   assign w_taken = ((bus.branchIn == 2'b01) && (bus.readRegister0In == bus.readRegister1In)) ||
                    ((bus.branchIn == 2'b10) && (bus.readRegister0In != bus.readRegister1In));

   assign w_mul_add = r_mplier[r_count] ? (r_mcand << r_count) : 32'd0;
   assign w_acc_nxt = r_acc + w_mul_add;

   always_comb begin
      w_state_nxt  = r_state;
      w_stall      = 1'b0;
      w_bubble     = 1'b0;
      w_load       = 1'b0;
      w_step       = 1'b0;
      w_retire_mul = 1'b0;
      if (bus.flushIn) begin
         w_state_nxt = ST_IDLE;
         w_bubble    = 1'b1;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.aluOpIn == c_OP_MUL) begin
                  w_stall     = 1'b1;
                  w_bubble    = 1'b1;
                  w_load      = 1'b1;
                  w_state_nxt = ST_MUL;
               end
            end
            ST_MUL: begin
               w_step = 1'b1;
               if (r_count == c_LAST) begin
                  w_retire_mul = 1'b1;
                  w_state_nxt  = ST_IDLE;
               end else begin
                  w_stall  = 1'b1;
                  w_bubble = 1'b1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

   // Stall is suppressed while reset is held so upstream never freezes in reset.
   assign bus.stallOut = w_stall & reset;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state  <= ST_IDLE;
         r_count  <= 5'd0;
         r_mcand  <= 32'd0;
         r_mplier <= 32'd0;
         r_acc    <= 32'd0;
      end else begin
         r_state <= w_state_nxt;
         if (bus.flushIn) begin
            r_count <= 5'd0;
         end else if (w_load) begin
            r_mcand  <= bus.readRegister0In;
            r_mplier <= w_opb;
            r_acc    <= 32'd0;
            r_count  <= 5'd0;
         end else if (w_step) begin
            r_acc   <= w_acc_nxt;
            r_count <= r_count + 5'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_alu_result    <= 32'd0;
         r_write_data    <= 32'd0;
         r_write_reg     <= 5'd0;
         r_branch_target <= 32'd0;
         r_branch_taken  <= 1'b0;
         r_mem_read      <= 1'b0;
         r_mem_write     <= 1'b0;
         r_mem_to_reg    <= 1'b0;
         r_reg_write     <= 1'b0;
         r_jump          <= 1'b0;
      end else begin
         r_write_data    <= bus.readRegister1In;
         r_write_reg     <= bus.regDstIn ? bus.addressRegisterRdIn : bus.addressRegisterRtIn;
         r_branch_target <= bus.pcMore4In + {bus.immediateExtendedIn[29:0], 2'b00};
         if (w_bubble) begin
            r_alu_result   <= 32'd0;
            r_branch_taken <= 1'b0;
            r_mem_read     <= 1'b0;
            r_mem_write    <= 1'b0;
            r_mem_to_reg   <= 1'b0;
            r_reg_write    <= 1'b0;
            r_jump         <= 1'b0;
         end else begin
            r_alu_result   <= w_retire_mul ? w_acc_nxt : w_alu;
            r_branch_taken <= w_taken;
            r_mem_read     <= bus.memReadIn;
            r_mem_write    <= bus.memWriteIn;
            r_mem_to_reg   <= bus.memToRegIn;
            r_reg_write    <= bus.regWriteIn;
            r_jump         <= bus.jumpIn;
         end
      end
   end

   assign bus.aluResultOut     = r_alu_result;
   assign bus.writeDataOut     = r_write_data;
   assign bus.writeRegisterOut = r_write_reg;
   assign bus.branchTakenOut   = r_branch_taken;
   assign bus.branchTargetOut  = r_branch_target;
   assign bus.memReadOut       = r_mem_read;
   assign bus.memWriteOut      = r_mem_write;
   assign bus.memToRegOut      = r_mem_to_reg;
   assign bus.regWriteOut      = r_reg_write;
   assign bus.jumpOut          = r_jump;

endmodule

`default_nettype wire

// File: tb/tb_ex_stage.sv
// ============================================================================
// Module      : tb_ex_stage
// Description : Scoreboard bench for ex_stage with hand-computed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ex_stage;
   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   ex_stage_if bus();
   ex_stage #(.MUL_CYCLES(32)) dut (.clk(clk), .reset(reset), .bus(bus.slave));

   // ctl = {regWrite, memRead, memWrite, memToReg, jump}
   typedef struct packed {
      logic [31:0] res;
      logic        bt;
      logic [4:0]  ctl;
      logic        cw;
      logic [4:0]  wr;
      logic        ct;
      logic [31:0] tgt;
   } exp_t;

   exp_t q[$];
   int   n_pass = 0;
   int   n_total = 0;
   logic done = 1'b0;

   function automatic exp_t mk(input logic [31:0] res, input logic bt, input logic [4:0] ctl,
                               input logic cw, input logic [4:0] wr,
                               input logic ct, input logic [31:0] tgt);
      exp_t e;
      e.res = res; e.bt = bt; e.ctl = ctl; e.cw = cw; e.wr = wr; e.ct = ct; e.tgt = tgt;
      return e;
   endfunction

   function automatic exp_t bubble();
      return mk(32'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 32'd0);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_total++;
      if (act === req) n_pass++;
      else $display("FAIL %s: actual=%h required=%h", name, act, req);
   endtask

   // Monitor: pops one expected EX/MEM record after every edge with pending stimulus.
   initial begin
      exp_t e;
      exp_t a;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            a.res = bus.aluResultOut;
            a.bt  = bus.branchTakenOut;
            a.ctl = {bus.regWriteOut, bus.memReadOut, bus.memWriteOut, bus.memToRegOut, bus.jumpOut};
            a.cw  = e.cw;
            a.wr  = e.cw ? bus.writeRegisterOut : 5'd0;
            a.ct  = e.ct;
            a.tgt = e.ct ? bus.branchTargetOut : 32'd0;
            n_total++;
            if (a === e) n_pass++;
            else $display("FAIL exmem: actual res=%h bt=%b ctl=%b wr=%0d tgt=%h required res=%h bt=%b ctl=%b wr=%0d tgt=%h",
                          a.res, a.bt, a.ctl, a.wr, a.tgt, e.res, e.bt, e.ctl, e.wr, e.tgt);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic defaults();
      bus.readRegister0In = '0; bus.readRegister1In = '0; bus.immediateExtendedIn = '0;
      bus.pcMore4In = '0; bus.addressRegisterRtIn = '0; bus.addressRegisterRdIn = '0;
      bus.regDstIn = 0; bus.jumpIn = 0; bus.memReadIn = 0; bus.memToRegIn = 0;
      bus.memWriteIn = 0; bus.aluSrcIn = 0; bus.regWriteIn = 0; bus.branchIn = 2'b00;
      bus.aluOpIn = 4'd13; bus.flushIn = 0;
   endtask

   task automatic alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      defaults();
      bus.aluOpIn = op; bus.readRegister0In = a; bus.readRegister1In = b;
   endtask

   // Called just after the negedge on which inputs were applied.
   task automatic cyc(input string name, input exp_t e, input logic st);
      #1;
      check({name, "_stall"}, {63'd0, bus.stallOut}, {63'd0, st});
      q.push_back(e);
      @(negedge clk);
   endtask

   // MUL with inputs held through the stall; flush_at < 0 means run to completion.
   task automatic do_mul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] prod,
                         input int flush_at);
      alu(4'd12, a, b);
      bus.regWriteIn = 1'b1; bus.regDstIn = 1'b1; bus.addressRegisterRdIn = 5'd9;
      cyc("mul_issue", bubble(), 1'b1);
      for (int k = 0; k < 32; k++) begin
         if (k == flush_at) begin
            bus.flushIn = 1'b1;
            cyc("mul_flush", bubble(), 1'b0);
            bus.flushIn = 1'b0;
            return;
         end
         if (k < 31) cyc("mul_busy", bubble(), 1'b1);
         else        cyc("mul_done", mk(prod, 1'b0, 5'b10000, 1'b1, 5'd9, 1'b0, 32'd0), 1'b0);
      end
   endtask

   initial begin
      defaults();
      // Reset with random inputs and a MUL request on the bus.
      bus.readRegister0In = $urandom; bus.readRegister1In = $urandom;
      bus.immediateExtendedIn = $urandom; bus.pcMore4In = $urandom;
      bus.regWriteIn = 1; bus.memReadIn = 1; bus.memWriteIn = 1; bus.jumpIn = 1;
      bus.memToRegIn = 1; bus.branchIn = 2'b01; bus.aluOpIn = 4'd12;
      repeat (3) @(negedge clk);
      #1;
      check("rst_stall", {63'd0, bus.stallOut}, 64'd0);
      check("rst_res", {32'd0, bus.aluResultOut}, 64'd0);
      check("rst_tgt_wd", {bus.branchTargetOut, bus.writeDataOut}, 64'd0);
      check("rst_ctl", {52'd0, bus.writeRegisterOut, bus.branchTakenOut, bus.regWriteOut,
                        bus.memReadOut, bus.memWriteOut, bus.memToRegOut, bus.jumpOut}, 64'd0);
      @(negedge clk);

      // First edge after release: ADD wrap.
      reset = 1'b1;
      alu(4'd0, 32'hFFFFFFFF, 32'd2);
      bus.regDstIn = 1; bus.addressRegisterRdIn = 5'd7; bus.regWriteIn = 1;
      cyc("add", mk(32'd1, 0, 5'b10000, 1, 5'd7, 0, 0), 1'b0);

      alu(4'd1, 32'd5, 32'd7);
      bus.addressRegisterRtIn = 5'd3; bus.memReadIn = 1; bus.memToRegIn = 1; bus.regWriteIn = 1;
      cyc("sub", mk(32'hFFFFFFFE, 0, 5'b11010, 1, 5'd3, 0, 0), 1'b0);

      alu(4'd6, 32'h80000000, 32'd1);
      cyc("slt", mk(32'd1, 0, 5'd0, 0, 0, 0, 0), 1'b0);
      alu(4'd7, 32'h80000000, 32'd1);
      cyc("sltu", mk(32'd0, 0, 5'd0, 0, 0, 0, 0), 1'b0);

      alu(4'd10, 32'd0, 32'h80000000); bus.immediateExtendedIn = 32'h00000100;
      cyc("sra", mk(32'hF8000000, 0, 5'd0, 0, 0, 0, 0), 1'b0);
      alu(4'd9, 32'd0, 32'h80000000); bus.immediateExtendedIn = 32'h00000100;
      cyc("srl", mk(32'h08000000, 0, 5'd0, 0, 0, 0, 0), 1'b0);

      alu(4'd5, 32'h0F0F0F0F, 32'hFFFFFFFF);
      bus.aluSrcIn = 1; bus.immediateExtendedIn = 32'h000000F0; bus.memWriteIn = 1; bus.jumpIn = 1;
      cyc("nor_imm", mk(32'hF0F0F000, 0, 5'b00101, 0, 0, 0, 0), 1'b0);

      alu(4'd11, 32'hDEADBEEF, 32'd0); bus.immediateExtendedIn = 32'h00001234;
      cyc("lui", mk(32'h12340000, 0, 5'd0, 0, 0, 0, 0), 1'b0);

      // BEQ taken then dropped: one-cycle pulse, backward target.
      alu(4'd0, 32'd5, 32'd5); bus.pcMore4In = 32'h100; bus.immediateExtendedIn = 32'hFFFFFFFF;
      bus.branchIn = 2'b01;
      cyc("beq", mk(32'd10, 1, 5'd0, 0, 0, 1, 32'hFC), 1'b0);
      bus.branchIn = 2'b00;
      cyc("beq_pulse", mk(32'd10, 0, 5'd0, 0, 0, 1, 32'hFC), 1'b0);
      bus.branchIn = 2'b10;
      cyc("bne_eq", mk(32'd10, 0, 5'd0, 0, 0, 1, 32'hFC), 1'b0);
      bus.readRegister1In = 32'd6;
      cyc("bne_ne", mk(32'd11, 1, 5'd0, 0, 0, 1, 32'hFC), 1'b0);
      // Compare ignores the immediate even when aluSrc selects it.
      bus.branchIn = 2'b01; bus.aluSrcIn = 1; bus.immediateExtendedIn = 32'd5;
      cyc("beq_rt", mk(32'd10, 0, 5'd0, 0, 0, 1, 32'h114), 1'b0);

      do_mul(32'h00010001, 32'h00010001, 32'h00020001, -1);
      alu(4'd0, 32'd1, 32'd2);
      cyc("add_after_mul", mk(32'd3, 0, 5'd0, 0, 0, 0, 0), 1'b0);

      do_mul(32'hFFFFFFFF, 32'd3, 32'hFFFFFFFD, -1);
      do_mul(32'd0, 32'd5, 32'd0, -1);

      do_mul(32'd3, 32'd4, 32'd12, 10);
      alu(4'd0, 32'd2, 32'd2);
      cyc("add_after_flush", mk(32'd4, 0, 5'd0, 0, 0, 0, 0), 1'b0);
      defaults();
      repeat (3) cyc("idle", bubble(), 1'b0);

      @(negedge clk);
      check("queue_drained", 64'(q.size()), 64'd0);
      done = 1'b1;
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule

`default_nettype wire
